// File: rtl/input_conditioner.sv
// -----------------------------------------------------------------------------
// input_conditioner
//
// Multi-channel conditioner for asynchronous board inputs (buttons, DTR, straps).
// Each channel is fully independent:
//   optional inversion -> N-stage synchroniser -> consecutive-sample debouncer
//   -> rise/fall strobes, plus a long-hold detector (level + one-cycle strobe).
//
// Ports:
//   i_clk       system clock
//   i_rst_n     asynchronous, active-low reset
//   i_in        raw asynchronous inputs, one bit per channel
//   o_level     debounced level (post-inversion)
//   o_rise_stb  one-cycle pulse when o_level goes 0->1
//   o_fall_stb  one-cycle pulse when o_level goes 1->0
//   o_held      high while o_level has been high for >= HOLD_CYCLES
//   o_held_stb  one-cycle pulse when o_held first asserts
// -----------------------------------------------------------------------------
module input_conditioner #(
  parameter int              N_CH            = 8,
  parameter int              SYNC_STAGES     = 2,
  parameter int              DEBOUNCE_CYCLES = 250000,
  parameter int              HOLD_CYCLES     = 5000000,
  parameter logic [N_CH-1:0] INVERT          = '0,
  parameter logic [N_CH-1:0] RESET_VAL       = '0
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic [N_CH-1:0] i_in,
  output logic [N_CH-1:0] o_level,
  output logic [N_CH-1:0] o_rise_stb,
  output logic [N_CH-1:0] o_fall_stb,
  output logic [N_CH-1:0] o_held,
  output logic [N_CH-1:0] o_held_stb
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

  // Elaboration-time guard on parameter ranges.
  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
    $error("input_conditioner: SYNC_STAGES must be in 2..4");
  end
  if (DEBOUNCE_CYCLES < 1 || HOLD_CYCLES < 1) begin : g_bad_cycles
    $error("input_conditioner: DEBOUNCE_CYCLES and HOLD_CYCLES must be >= 1");
  end

  for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic [DB_W-1:0]        db_cnt;
    logic [HOLD_W-1:0]      h_cnt;
    logic                   level_q;
    logic                   rise_q;
    logic                   fall_q;
    logic                   held_q;
    logic                   held_stb_q;

    assign s = sync_q[SYNC_STAGES-1];

    // Synchroniser. Inversion happens before the first flop so everything
    // downstream, including the reset value, is in post-inversion terms.
    // NOTE: sequential state uses non-blocking assignments so every flop in
    // the chain samples the value its predecessor held before this edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        sync_q <= {SYNC_STAGES{RESET_VAL[ch]}};
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], i_in[ch] ^ INVERT[ch]};
      end
    end

    // Debouncer: the level flips only after DEBOUNCE_CYCLES consecutive
    // disagreeing samples; any agreeing sample restarts the count.
    // NOTE: strobes are assigned low first in the clocked branch, so they are
    // high for exactly one cycle unless the flip condition re-asserts them.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        db_cnt  <= '0;
        level_q <= RESET_VAL[ch];
        rise_q  <= 1'b0;
        fall_q  <= 1'b0;
      end else begin
        rise_q <= 1'b0;
        fall_q <= 1'b0;
        if (s == level_q) begin
          db_cnt <= '0;
        end else if (db_cnt == DB_LAST) begin
          level_q <= s;
          db_cnt  <= '0;
          rise_q  <= s;
          fall_q  <= ~s;
        end else begin
          db_cnt <= db_cnt + 1'b1;
        end
      end
    end

    // Long-hold detector: counts cycles of high level, saturates once held.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        h_cnt      <= '0;
        held_q     <= 1'b0;
        held_stb_q <= 1'b0;
      end else begin
        held_stb_q <= 1'b0;
        if (!level_q) begin
          h_cnt  <= '0;
          held_q <= 1'b0;
        end else if (!held_q) begin
          h_cnt <= h_cnt + 1'b1;
          if (h_cnt == HOLD_LAST) begin
            held_q     <= 1'b1;
            held_stb_q <= 1'b1;
          end
        end
      end
    end

    assign o_level[ch]    = level_q;
    assign o_rise_stb[ch] = rise_q;
    assign o_fall_stb[ch] = fall_q;
    assign o_held[ch]     = held_q;
    assign o_held_stb[ch] = held_stb_q;
  end

endmodule

// File: tb/tb_input_conditioner.sv
// -----------------------------------------------------------------------------
// tb_input_conditioner
//
// Self-checking bench for input_conditioner. A history-window reference model
// predicts every output each cycle; predictions are queued at the sampling
// edge and compared against the DUT on the following falling edge.
// -----------------------------------------------------------------------------
module tb_input_conditioner;

  localparam int         N_CH = 4;
  localparam int         SYNC = 2;
  localparam int         DB   = 4;
  localparam int         HOLD = 10;
  localparam logic [3:0] INV  = 4'b1000;
  localparam logic [3:0] RV   = 4'b1000;

  logic       i_clk   = 1'b0;
  logic       i_rst_n = 1'b0;
  logic [3:0] i_in    = 4'b0000;
  logic [3:0] o_level;
  logic [3:0] o_rise_stb;
  logic [3:0] o_fall_stb;
  logic [3:0] o_held;
  logic [3:0] o_held_stb;

  always #5 i_clk = ~i_clk;

  input_conditioner #(
    .N_CH            (N_CH),
    .SYNC_STAGES     (SYNC),
    .DEBOUNCE_CYCLES (DB),
    .HOLD_CYCLES     (HOLD),
    .INVERT          (INV),
    .RESET_VAL       (RV)
  ) dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_in       (i_in),
    .o_level    (o_level),
    .o_rise_stb (o_rise_stb),
    .o_fall_stb (o_fall_stb),
    .o_held     (o_held),
    .o_held_stb (o_held_stb)
  );

  typedef struct packed {
    logic [3:0] level;
    logic [3:0] rise;
    logic [3:0] fall;
    logic [3:0] held;
    logic [3:0] hstb;
  } exp_t;

  exp_t sb_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, act, exp, $time);
    end
  endtask

  // Reference model state.
  // xh[i] = post-inversion input sampled i edges ago (xh[0] = this edge).
  // lh[i] = o_level after the edge i edges before this one (lh[0] = current).
  logic [3:0] xh [SYNC+DB];
  logic [3:0] lh [HOLD];
  logic [3:0] held_m;

  task automatic model_reset();
    for (int i = 0; i < SYNC + DB; i++) xh[i] = RV;
    for (int i = 0; i < HOLD; i++) lh[i] = 4'b0000;
    lh[0]  = RV;
    held_m = 4'b0000;
  endtask

  task automatic model_step(input logic [3:0] x, output exp_t e);
    logic [3:0] lvl_old;
    logic [3:0] lvl_new;
    logic [3:0] all_diff;
    logic [3:0] all_high;
    lvl_old = lh[0];
    for (int i = SYNC + DB - 1; i > 0; i--) xh[i] = xh[i-1];
    xh[0] = x;
    // The debouncer sees the value that left the synchroniser; it flips once
    // the last DB such values all disagree with the current level.
    all_diff = 4'b1111;
    for (int i = 0; i < DB; i++) all_diff &= (xh[SYNC+i] ^ lvl_old);
    lvl_new = lvl_old ^ all_diff;
    // Held after this edge iff level was high after each of the last HOLD edges.
    all_high = 4'b1111;
    for (int i = 0; i < HOLD; i++) all_high &= lh[i];
    e.hstb  = all_high & ~held_m;
    e.held  = all_high;
    held_m  = all_high;
    e.level = lvl_new;
    e.rise  = lvl_new & ~lvl_old;
    e.fall  = ~lvl_new & lvl_old;
    for (int i = HOLD - 1; i > 0; i--) lh[i] = lh[i-1];
    lh[0] = lvl_new;
  endtask

  task automatic tick();
    exp_t e;
    exp_t got;
    @(posedge i_clk);
    model_step(i_in ^ INV, e);
    sb_q.push_back(e);
    @(negedge i_clk);
    if (sb_q.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      got = sb_q.pop_front();
      check("o_level",    32'(o_level),    32'(got.level));
      check("o_rise_stb", 32'(o_rise_stb), 32'(got.rise));
      check("o_fall_stb", 32'(o_fall_stb), 32'(got.fall));
      check("o_held",     32'(o_held),     32'(got.held));
      check("o_held_stb", 32'(o_held_stb), 32'(got.hstb));
      check("rise_fall_exclusive", 32'(o_rise_stb & o_fall_stb), 32'd0);
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_level"},    32'(o_level),    32'(RV));
    check({tag, "_rise"},     32'(o_rise_stb), 32'd0);
    check({tag, "_fall"},     32'(o_fall_stb), 32'd0);
    check({tag, "_held"},     32'(o_held),     32'd0);
    check({tag, "_held_stb"}, 32'(o_held_stb), 32'd0);
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge i_clk);
    check_reset_outputs("por");
    i_rst_n = 1'b1;

    // Idle out of reset: ch3 sits at its inverted reset level and goes held.
    run(14);
    check("ch3_held_idle", 32'(o_held[3]), 32'd1);
    check("idle_level",    32'(o_level),   32'(4'b1000));

    // Clean ch0 press, held long enough to reach o_held.
    i_in[0] = 1'b1;
    run(20);
    check("ch0_held_press", 32'(o_held[0]), 32'd1);

    // Glitch train on ch1: 3 high, 1 low, 3 high, then low.
    i_in[1] = 1'b1; run(3);
    i_in[1] = 1'b0; run(1);
    i_in[1] = 1'b1; run(3);
    i_in[1] = 1'b0; run(8);
    check("ch1_glitch_rejected", 32'(o_level[1]), 32'd0);

    // Release ch0 after held.
    i_in[0] = 1'b0;
    run(10);
    check("ch0_released", 32'(o_held[0]), 32'd0);

    // ch2 short press (level high 6 cycles), then a long press.
    i_in[2] = 1'b1; run(6);
    i_in[2] = 1'b0; run(12);
    i_in[2] = 1'b1; run(18);
    check("ch2_long_held", 32'(o_held[2]), 32'd1);
    i_in[2] = 1'b0; run(10);

    // ch2 mid-hold and ch0 mid-debounce, then an async reset pulse.
    i_in[2] = 1'b1; run(8);
    i_in[0] = 1'b1; run(4);
    check("pre_reset_ch2_level", 32'(o_level[2]), 32'd1);
    #1 i_rst_n = 1'b0;
    #1 check_reset_outputs("async_rst");
    #1 i_rst_n = 1'b1;
    model_reset();

    // Both channels re-debounce from zero and reach held.
    run(25);
    check("ch0_held_after_rst", 32'(o_held[0]), 32'd1);
    check("ch2_held_after_rst", 32'(o_held[2]), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/input_conditioner.md
Name: input_conditioner

Overview:
- Multi-channel conditioner for asynchronous board inputs such as buttons, UART DTR and strap pins. Replaces the per-signal chain of 2FF synchroniser, edge detector and minimum-duration trigger at the top level.
- Each channel has:
  - configurable polarity inversion
  - an N-stage synchroniser
  - a consecutive-sample debouncer
  - rise/fall strobes
  - a long-hold detector with a level output and a one-cycle strobe
- Outputs feed the CPU GPIO inputs, reset logic and the bootloader-entry trigger.

Parameters:
- N_CH, 8, number of independent channels.
- SYNC_STAGES, 2, synchroniser flops per channel; legal range 2..4.
- DEBOUNCE_CYCLES, 250000, consecutive disagreeing samples required to change o_level; must be >= 1.
- HOLD_CYCLES, 5000000, cycles o_level must stay high before o_held asserts; must be >= 1.
- INVERT, {N_CH{1'b0}}, per-channel mask; a 1 inverts i_in before synchronisation (active-low buttons, DTR_n).
- RESET_VAL, {N_CH{1'b0}}, per-channel reset value of the synchroniser flops and o_level (post-inversion).

Ports:
- i_clk  in  1  system clock
- i_rst_n  in  1  asynchronous, active-low reset
- i_in  in  N_CH  raw asynchronous inputs
- o_level  out  N_CH  debounced level, post-inversion
- o_rise_stb  out  N_CH  one-cycle pulse when o_level goes 0->1
- o_fall_stb  out  N_CH  one-cycle pulse when o_level goes 1->0
- o_held  out  N_CH  high while o_level has been high >= HOLD_CYCLES
- o_held_stb  out  N_CH  one-cycle pulse when o_held first asserts

Behaviour:
- Reset: single clock domain (i_clk); reset is asynchronous, active-low (i_rst_n). Assertion immediately sets:
  - sync flops and o_level to RESET_VAL
  - debounce and hold counters to 0
  - o_rise_stb, o_fall_stb, o_held and o_held_stb to 0
- Reset release has no special handling. If the input differs from RESET_VAL, the channel debounces normally and emits the matching strobe.
- Channels are fully independent. There is no shared state and no cross-channel interaction.
- Synchroniser: a chain of SYNC_STAGES flops fed by i_in ^ INVERT; s is the last stage.
- Debouncer, per channel, with counter db_cnt of width $clog2(DEBOUNCE_CYCLES+1):
  - s == o_level: db_cnt <= 0.
  - s != o_level and db_cnt == DEBOUNCE_CYCLES-1: o_level <= s, db_cnt <= 0, and assert o_rise_stb or o_fall_stb on the same edge.
  - otherwise: db_cnt <= db_cnt+1.
  - A single agreeing sample anywhere in the run restarts the count, so glitches shorter than DEBOUNCE_CYCLES are fully rejected.
- Latency: new input value sampled at edge k -> o_level changes after edge k+SYNC_STAGES+DEBOUNCE_CYCLES-1.
- Strobes: registered and high for exactly one cycle. Rise and fall are never high together on one channel.
- Hold detector, per channel, with counter h_cnt of width $clog2(HOLD_CYCLES+1):
  - o_level == 0: h_cnt <= 0, o_held <= 0.
  - o_level == 1 and o_held == 0: h_cnt <= h_cnt+1. On the edge where h_cnt == HOLD_CYCLES-1, o_held <= 1 and o_held_stb <= 1.
  - o_held == 1: h_cnt holds (saturates); no further o_held_stb.
- Hold timing:
  - If o_level rises after edge r, o_held and o_held_stb assert after edge r+HOLD_CYCLES.
  - o_held deasserts on the edge after o_level falls.
  - A release before HOLD_CYCLES clears h_cnt; the next press restarts from 0.
- Reset mid-count, in either counter: all state is cleared asynchronously and any pending strobe is lost.

Test Plan (N_CH=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, HOLD_CYCLES=10, INVERT=4'b1000, RESET_VAL=4'b1000):
- Out of reset with i_in=4'b0000 held:
  - o_level=4'b1000 throughout (ch3 raw 0 inverts to 1 = RESET_VAL).
  - All strobes stay 0.
  - o_held[3] asserts after edge 10, i.e. HOLD_CYCLES after reset release.
- Clean ch0 press: i_in[0] 0->1 sampled at edge k, held high ->
  - o_level[0]=1 and o_rise_stb[0]=1 after edge k+5; strobe low after edge k+6.
  - o_held[0] and o_held_stb[0] asserted after edge k+15; o_held_stb[0] low next cycle.
- Glitch rejection on ch1: i_in[1] high for 3 cycles, low 1 cycle, high 3 cycles ->
  - o_level[1] never changes.
  - No strobes.
- Release ch0 after o_held:
  - i_in[0] 1->0 sampled at edge j -> o_fall_stb[0]=1 and o_level[0]=0 after edge j+5.
  - o_held[0]=0 after edge j+6.
- Short press on ch2 (level high 6 cycles), then a long press:
  - First press gives rise and fall strobes but no o_held.
  - Second press asserts o_held[2] exactly 10 cycles after its rise.
- Async reset:
  - Pulse i_rst_n low mid-debounce on ch0 and mid-hold on ch2 -> all outputs return to reset values immediately, without waiting for a clock edge.
  - After release, both channels re-debounce from a zero count.
